// File: rtl/zynet_run_ctrl.sv
// Run-level scheduler for one zyNet inference: frame capture, serializer handoff, start pulse,
// timed wait for the result, and result hold for the host.
module zynet_run_ctrl #(
  parameter int unsigned INPUT_LAYER_HEIGHT  = 256,
  parameter int unsigned OUTPUT_LAYER_HEIGHT = 10,
  parameter int unsigned WORD_SIZE           = 16,
  parameter int unsigned START_DELAY         = 2,
  parameter int unsigned TIMEOUT_CYCLES      = 65535,
  parameter int unsigned CNT_W               = 16
) (
  input  logic                                                clk_i,
  input  logic                                                reset_i,
  input  logic                                                host_valid_i,
  output logic                                                host_ready_o,
  input  logic [INPUT_LAYER_HEIGHT-1:0][WORD_SIZE-1:0]        host_data_i,
  output logic                                                ser_valid_o,
  input  logic                                                ser_ready_i,
  output logic [INPUT_LAYER_HEIGHT-1:0][WORD_SIZE-1:0]        ser_data_o,
  output logic                                                net_start_o,
  input  logic                                                net_valid_i,
  input  logic [OUTPUT_LAYER_HEIGHT-1:0][WORD_SIZE-1:0]       net_data_i,
  output logic                                                net_yumi_o,
  output logic                                                res_valid_o,
  output logic [OUTPUT_LAYER_HEIGHT-1:0][WORD_SIZE-1:0]       res_data_o,
  input  logic                                                res_yumi_i,
  input  logic                                                clear_i,
  output logic                                                busy_o,
  output logic                                                timeout_o,
  output logic [CNT_W-1:0]                                    frame_count_o
);

  localparam int unsigned DlyW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StGap,
    StStart,
    StWait,
    StResult,
    StErr
  } state_t;

  state_t r_state, w_state_next;

  logic [INPUT_LAYER_HEIGHT-1:0][WORD_SIZE-1:0]  r_frame;
  logic [OUTPUT_LAYER_HEIGHT-1:0][WORD_SIZE-1:0] r_result;
  logic [DlyW-1:0]  r_dly, w_dly_next;
  logic [TmrW-1:0]  r_tmr, w_tmr_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_timeout, w_timeout_next;
  logic             w_host_acc;
  logic             w_net_acc;

  assign w_host_acc = (r_state == StIdle) && host_valid_i;
  // A result is only popped while waiting; valid elsewhere is left untouched.
  assign w_net_acc  = (r_state == StWait) && net_valid_i;

  always_comb begin
    w_state_next   = r_state;
    w_dly_next     = r_dly;
    w_tmr_next     = r_tmr;
    w_cnt_next     = r_cnt;
    w_timeout_next = r_timeout;
    unique case (r_state)
      StIdle: begin
        if (host_valid_i) w_state_next = StLoad;
      end
      StLoad: begin
        if (ser_ready_i) begin
          w_state_next = StGap;
          w_dly_next   = '0;
        end
      end
      StGap: begin
        if (r_dly == DlyW'(START_DELAY - 1)) begin
          w_state_next = StStart;
        end else begin
          w_dly_next = r_dly + DlyW'(1);
        end
      end
      StStart: begin
        w_state_next = StWait;
        w_tmr_next   = '0;
      end
      StWait: begin
        w_tmr_next = r_tmr + TmrW'(1);
        // A result arriving on the final cycle still beats the timeout.
        if (net_valid_i) begin
          w_state_next = StResult;
        end else if (r_tmr == TmrW'(TIMEOUT_CYCLES - 1)) begin
          w_state_next   = StErr;
          w_timeout_next = 1'b1;
        end
      end
      StResult: begin
        if (res_yumi_i) begin
          w_state_next = StIdle;
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      StErr: begin
        if (clear_i) begin
          w_state_next   = StIdle;
          w_timeout_next = 1'b0;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= StIdle;
      r_frame   <= '0;
      r_result  <= '0;
      r_dly     <= '0;
      r_tmr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_dly     <= w_dly_next;
      r_tmr     <= w_tmr_next;
      r_cnt     <= w_cnt_next;
      r_timeout <= w_timeout_next;
      if (w_host_acc) r_frame  <= host_data_i;
      if (w_net_acc)  r_result <= net_data_i;
    end
  end

  assign host_ready_o  = (r_state == StIdle);
  assign ser_valid_o   = (r_state == StLoad);
  assign ser_data_o    = r_frame;
  assign net_start_o   = (r_state == StStart);
  assign net_yumi_o    = w_net_acc;
  assign res_valid_o   = (r_state == StResult);
  assign res_data_o    = r_result;
  assign busy_o        = (r_state != StIdle);
  assign timeout_o     = r_timeout;
  assign frame_count_o = r_cnt;

endmodule
